// File: rtl/vtg_pkg.sv
// vtg_pkg: shared constants and types for the video timing generator.
// - CoordW / CoordMax : counter and coordinate width, largest supported total
// - vtg_timing_t      : one complete raster timing set
// - Timing640x480     : 640x480@60 (the generator defaults)
// - Timing1280x720    : 1280x720@60, positive sync polarity
// - rgb_t, bar_colour : 8-entry colour bar table used by the optional pattern
package vtg_pkg;

    localparam int unsigned CoordW   = 12;
    localparam int unsigned CoordMax = 1 << CoordW;
    localparam int unsigned NumBars  = 8;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          h_pol;
        bit          v_pol;
    } vtg_timing_t;

    localparam vtg_timing_t Timing640x480 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_pol: 1'b0,   v_pol: 1'b0
    };

    localparam vtg_timing_t Timing1280x720 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
        h_pol: 1'b1,    v_pol: 1'b1
    };

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = '{red: 8'hFF, green: 8'hFF, blue: 8'hFF};
            3'd1:    c = '{red: 8'hFF, green: 8'hFF, blue: 8'h00};
            3'd2:    c = '{red: 8'h00, green: 8'hFF, blue: 8'hFF};
            3'd3:    c = '{red: 8'h00, green: 8'hFF, blue: 8'h00};
            3'd4:    c = '{red: 8'hFF, green: 8'h00, blue: 8'hFF};
            3'd5:    c = '{red: 8'hFF, green: 8'h00, blue: 8'h00};
            3'd6:    c = '{red: 8'h00, green: 8'h00, blue: 8'hFF};
            default: c = '{red: 8'h00, green: 8'h00, blue: 8'h00};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: raster timing bundle between the generator and the TMDS encoders.
// - i_en                      : advance enable into the generator
// - o_de, o_hsync, o_vsync    : data enable and syncs
// - o_ctrl                    : {o_vsync, o_hsync}, blue-channel control
// - o_x, o_y                  : position of the current output
// - o_line_start, o_frame_start : single-cycle position markers
// - o_red, o_green, o_blue    : 8-bit channel data
// Modports: master = generator side, slave = consumer side.
interface video_timing_gen_if;
    import vtg_pkg::*;

    logic              i_en;
    logic              o_de;
    logic              o_hsync;
    logic              o_vsync;
    logic [1:0]        o_ctrl;
    logic [CoordW-1:0] o_x;
    logic [CoordW-1:0] o_y;
    logic              o_line_start;
    logic              o_frame_start;
    logic [7:0]        o_red;
    logic [7:0]        o_green;
    logic [7:0]        o_blue;

    modport master (
        input  i_en,
        output o_de, o_hsync, o_vsync, o_ctrl, o_x, o_y,
        output o_line_start, o_frame_start, o_red, o_green, o_blue
    );

    modport slave (
        output i_en,
        input  o_de, o_hsync, o_vsync, o_ctrl, o_x, o_y,
        input  o_line_start, o_frame_start, o_red, o_green, o_blue
    );

endinterface

// File: rtl/vtg_counter.sv
// vtg_counter: enabled up-counter that wraps from MAX back to 0.
// - i_clk, i_rst : clock, synchronous active-high reset
// - en           : advance this cycle
// - count        : current value
// - wrap         : high when this cycle's advance wraps MAX -> 0
module vtg_counter #(
    parameter int unsigned MAX   = 799,
    parameter int unsigned WIDTH = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic at_max;

    assign at_max = (count == MaxVal);
    assign wrap   = en && at_max;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (en) begin
            count <= at_max ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing for the DVI/HDMI transmit path.
// Ports:
// - i_clk : pixel clock
// - i_rst : synchronous reset, active-high, priority over enable
// - vid   : video_timing_gen_if.master (enable in; de, syncs, ctrl, x/y, start pulses, RGB out)
// All outputs are registered and reflect the counter position of the previous enabled cycle.
// Optional feature: define VTG_PATTERN_EN for 8 vertical colour bars on the RGB outputs;
// otherwise the RGB outputs are tied to zero.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned H_ACTIVE = Timing640x480.h_active,
    parameter int unsigned H_FP     = Timing640x480.h_fp,
    parameter int unsigned H_SYNC   = Timing640x480.h_sync,
    parameter int unsigned H_BP     = Timing640x480.h_bp,
    parameter int unsigned V_ACTIVE = Timing640x480.v_active,
    parameter int unsigned V_FP     = Timing640x480.v_fp,
    parameter int unsigned V_SYNC   = Timing640x480.v_sync,
    parameter int unsigned V_BP     = Timing640x480.v_bp,
    parameter bit          H_POL    = Timing640x480.h_pol,
    parameter bit          V_POL    = Timing640x480.v_pol
) (
    input  logic               i_clk,
    input  logic               i_rst,
    video_timing_gen_if.master vid
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
    localparam int unsigned HSyncEnd   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
    localparam int unsigned VSyncEnd   = V_ACTIVE + V_FP + V_SYNC;

    if (H_TOTAL > CoordMax || V_TOTAL > CoordMax) begin : g_size_check
        $error("video_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
    end

    logic [CoordW-1:0] hc;
    logic [CoordW-1:0] vc;
    logic              h_wrap;
    logic              v_wrap;
    logic              v_en;
    logic [31:0]       hc_w;
    logic [31:0]       vc_w;

    logic              de_raw;
    logic              hs_raw;
    logic              vs_raw;
    logic              line_start_raw;

    // High while the counters sit at (0,0); avoids a full-width compare on both counters.
    logic              at_origin_q;

    logic              de_q;
    logic              hsync_q;
    logic              vsync_q;
    logic [CoordW-1:0] x_q;
    logic [CoordW-1:0] y_q;
    logic              line_start_q;
    logic              frame_start_q;

    assign v_en = vid.i_en & h_wrap;

    vtg_counter #(
        .MAX   (H_TOTAL - 1),
        .WIDTH (CoordW)
    ) u_h_counter (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .en    (vid.i_en),
        .count (hc),
        .wrap  (h_wrap)
    );

    vtg_counter #(
        .MAX   (V_TOTAL - 1),
        .WIDTH (CoordW)
    ) u_v_counter (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .en    (v_en),
        .count (vc),
        .wrap  (v_wrap)
    );

    always_comb begin
        hc_w           = 32'(hc);
        vc_w           = 32'(vc);
        de_raw         = (hc_w < H_ACTIVE) && (vc_w < V_ACTIVE);
        hs_raw         = (hc_w >= HSyncStart) && (hc_w < HSyncEnd);
        // Vertical sync follows whole lines, so it depends on vc only.
        vs_raw         = (vc_w >= VSyncStart) && (vc_w < VSyncEnd);
        line_start_raw = (hc == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            at_origin_q   <= 1'b1;
            de_q          <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (vid.i_en) begin
            // Any advance leaves the origin unless it is the end-of-frame wrap.
            at_origin_q   <= v_wrap;
            de_q          <= de_raw;
            hsync_q       <= hs_raw ? H_POL : ~H_POL;
            vsync_q       <= vs_raw ? V_POL : ~V_POL;
            x_q           <= hc;
            y_q           <= vc;
            line_start_q  <= line_start_raw;
            frame_start_q <= at_origin_q;
        end
    end

    assign vid.o_de          = de_q;
    assign vid.o_hsync       = hsync_q;
    assign vid.o_vsync       = vsync_q;
    assign vid.o_ctrl        = {vsync_q, hsync_q};
    assign vid.o_x           = x_q;
    assign vid.o_y           = y_q;
    assign vid.o_line_start  = line_start_q;
    assign vid.o_frame_start = frame_start_q;

`ifdef VTG_PATTERN_EN
    logic [2:0] bar_idx;
    rgb_t       rgb_d;
    rgb_t       rgb_q;

    always_comb begin
        // Only meaningful inside the active region, where hc < H_ACTIVE keeps this below 8.
        bar_idx = 3'((hc_w * NumBars) / H_ACTIVE);
        rgb_d   = '0;
        if (de_raw) begin
            rgb_d = bar_colour(bar_idx);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rgb_q <= '0;
        end else if (vid.i_en) begin
            rgb_q <= rgb_d;
        end
    end

    assign vid.o_red   = rgb_q.red;
    assign vid.o_green = rgb_q.green;
    assign vid.o_blue  = rgb_q.blue;
`else
    assign vid.o_red   = '0;
    assign vid.o_green = '0;
    assign vid.o_blue  = '0;
`endif

endmodule
